// File: rtl/sm3_arb_if.sv
// Bundle of the two requester message streams, the shared SM3 core port and the result/status
// outputs of the two-requester SM3 arbiter.
interface sm3_arb_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0]   req0_msg_d;
  logic [DW/8-1:0] req0_msg_vld_byte;
  logic            req0_msg_vld;
  logic            req0_msg_lst;
  logic            req0_msg_rdy;

  logic [DW-1:0]   req1_msg_d;
  logic [DW/8-1:0] req1_msg_vld_byte;
  logic            req1_msg_vld;
  logic            req1_msg_lst;
  logic            req1_msg_rdy;

  logic [DW-1:0]   core_msg_d;
  logic [DW/8-1:0] core_msg_vld_byte;
  logic            core_msg_vld;
  logic            core_msg_lst;
  logic            core_msg_rdy;
  logic [255:0]    core_res;
  logic            core_res_vld;

  logic [255:0]    res_d;
  logic            res_id;
  logic            res_vld;
  logic            tmo_err;
  logic            busy;
  logic            gnt_id;

  // Arbiter view.
  modport slave (
    input  req0_msg_d, req0_msg_vld_byte, req0_msg_vld, req0_msg_lst,
    input  req1_msg_d, req1_msg_vld_byte, req1_msg_vld, req1_msg_lst,
    input  core_msg_rdy, core_res, core_res_vld,
    output req0_msg_rdy, req1_msg_rdy,
    output core_msg_d, core_msg_vld_byte, core_msg_vld, core_msg_lst,
    output res_d, res_id, res_vld, tmo_err, busy, gnt_id
  );

  // Requester/core side view.
  modport master (
    output req0_msg_d, req0_msg_vld_byte, req0_msg_vld, req0_msg_lst,
    output req1_msg_d, req1_msg_vld_byte, req1_msg_vld, req1_msg_lst,
    output core_msg_rdy, core_res, core_res_vld,
    input  req0_msg_rdy, req1_msg_rdy,
    input  core_msg_d, core_msg_vld_byte, core_msg_vld, core_msg_lst,
    input  res_d, res_id, res_vld, tmo_err, busy, gnt_id
  );
endinterface

// File: rtl/sm3_arb.sv
// Two-requester arbiter in front of a shared SM3 core: grants one whole message at a time,
// waits for the digest (with timeout) and alternates priority after each completed job.
module sm3_arb #(
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 1024
) (
  input logic     clk,
  input logic     rst,
  sm3_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStream, StWaitRes} state_e;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic            gnt_q, gnt_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [255:0]    dig_q, dig_d;
  logic            rid_q, rid_d;
  logic            rvld_q, rvld_d;
  logic            tmo_q, tmo_d;

  logic [DW-1:0]   c_d;
  logic [DW/8-1:0] c_vb;
  logic            c_vld, c_lst, rdy0, rdy1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      tcnt_q  <= '0;
      dig_q   <= '0;
      rid_q   <= 1'b0;
      rvld_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      tcnt_q  <= tcnt_d;
      dig_q   <= dig_d;
      rid_q   <= rid_d;
      rvld_q  <= rvld_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    tcnt_d  = tcnt_q;
    dig_d   = dig_q;
    rid_d   = rid_q;
    rvld_d  = 1'b0;
    tmo_d   = 1'b0;
    c_d     = '0;
    c_vb    = '0;
    c_vld   = 1'b0;
    c_lst   = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req0_msg_vld && bus.req1_msg_vld) begin
          gnt_d   = prio_q;
          state_d = StStream;
        end else if (bus.req0_msg_vld) begin
          gnt_d   = 1'b0;
          state_d = StStream;
        end else if (bus.req1_msg_vld) begin
          gnt_d   = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (gnt_q) begin
          c_d   = bus.req1_msg_d;
          c_vb  = bus.req1_msg_vld_byte;
          c_vld = bus.req1_msg_vld;
          c_lst = bus.req1_msg_lst;
          rdy1  = bus.core_msg_rdy;
        end else begin
          c_d   = bus.req0_msg_d;
          c_vb  = bus.req0_msg_vld_byte;
          c_vld = bus.req0_msg_vld;
          c_lst = bus.req0_msg_lst;
          rdy0  = bus.core_msg_rdy;
        end
        if (c_vld && bus.core_msg_rdy && c_lst) begin
          state_d = StWaitRes;
          tcnt_d  = '0;
        end
      end
      StWaitRes: begin
        // A digest arriving in the expiry cycle takes precedence over the timeout.
        if (bus.core_res_vld) begin
          dig_d   = bus.core_res;
          rid_d   = gnt_q;
          rvld_d  = 1'b1;
          prio_d  = ~gnt_q;
          state_d = StIdle;
        end else if (tcnt_q == 16'(TMO - 1)) begin
          tmo_d   = 1'b1;
          prio_d  = ~gnt_q;
          state_d = StIdle;
        end else begin
          tcnt_d  = tcnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.core_msg_d        = c_d;
  assign bus.core_msg_vld_byte = c_vb;
  assign bus.core_msg_vld      = c_vld;
  assign bus.core_msg_lst      = c_lst;
  assign bus.req0_msg_rdy      = rdy0;
  assign bus.req1_msg_rdy      = rdy1;
  assign bus.res_d             = dig_q;
  assign bus.res_id            = rid_q;
  assign bus.res_vld           = rvld_q;
  assign bus.tmo_err           = tmo_q;
  assign bus.busy              = (state_q != StIdle);
  assign bus.gnt_id            = gnt_q;

endmodule

// File: tb/tb_sm3_arb.sv
// Directed bench for sm3_arb: single job, contention/alternation, backpressure, timeout,
// result-vs-timeout race, stray digest and asynchronous reset mid-stream.
module tb_sm3_arb;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [255:0] Dig0 =
    256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] Dig1 = 256'h1111_2222_3333_4444;
  localparam logic [255:0] Dig2 = 256'hab_cdef;
  localparam logic [255:0] Dig3 = 256'hdead_beef_0000_0001;

  sm3_arb_if #(.DW(DW)) bus ();

  sm3_arb #(.DW(DW), .TMO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req0_msg_d = '0; bus.req0_msg_vld_byte = '0; bus.req0_msg_vld = 1'b0;
    bus.req0_msg_lst = 1'b0;
    bus.req1_msg_d = '0; bus.req1_msg_vld_byte = '0; bus.req1_msg_vld = 1'b0;
    bus.req1_msg_lst = 1'b0;
    bus.core_msg_rdy = 1'b0; bus.core_res = '0; bus.core_res_vld = 1'b0;

    // Reset state, with a request pending that must not be accepted.
    bus.req0_msg_vld = 1'b1;
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", bus.gnt_id, 0);
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_tmo", bus.tmo_err, 0);
    check("rst_res_d", bus.res_d, 0);
    check("rst_rdy0", bus.req0_msg_rdy, 0);
    check("rst_core_vld", bus.core_msg_vld, 0);
    bus.req0_msg_vld = 1'b0;
    rst = 1'b0;

    // Single requester, 3 words.
    tick();
    bus.req0_msg_vld = 1'b1; bus.req0_msg_d = 32'h6162_6380; bus.req0_msg_vld_byte = 4'hf;
    bus.core_msg_rdy = 1'b1;
    #1;
    check("idle_rdy0", bus.req0_msg_rdy, 0);
    check("idle_core_vld", bus.core_msg_vld, 0);
    tick();
    check("s1_busy", bus.busy, 1);
    check("s1_gnt", bus.gnt_id, 0);
    check("s1_core_d", bus.core_msg_d, 32'h6162_6380);
    check("s1_core_vld", bus.core_msg_vld, 1);
    check("s1_rdy0", bus.req0_msg_rdy, 1);
    check("s1_rdy1", bus.req1_msg_rdy, 0);
    tick();
    bus.req0_msg_d = 32'h0000_0000;
    tick();
    bus.req0_msg_d = 32'h0000_0018; bus.req0_msg_lst = 1'b1;
    #1;
    check("s1_lst", bus.core_msg_lst, 1);
    tick();
    bus.req0_msg_vld = 1'b0; bus.req0_msg_lst = 1'b0;
    #1;
    check("s1_wait_core_vld", bus.core_msg_vld, 0);
    check("s1_wait_core_d", bus.core_msg_d, 0);
    check("s1_wait_busy", bus.busy, 1);
    bus.core_res = Dig0; bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    check("s1_res_vld", bus.res_vld, 1);
    check("s1_res_id", bus.res_id, 0);
    check("s1_res_d", bus.res_d, Dig0);
    check("s1_idle", bus.busy, 0);
    tick();
    check("s1_res_pulse", bus.res_vld, 0);
    check("s1_res_hold", bus.res_d, Dig0);

    // Contention after reset: req0 first, then req1, then req0 again.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req0_msg_vld = 1'b1; bus.req0_msg_lst = 1'b1; bus.req0_msg_d = 32'haaaa_0000;
    bus.req1_msg_vld = 1'b1; bus.req1_msg_lst = 1'b1; bus.req1_msg_d = 32'hbbbb_0000;
    bus.req1_msg_vld_byte = 4'h1;
    tick();
    check("c_gnt_a", bus.gnt_id, 0);
    check("c_core_d_a", bus.core_msg_d, 32'haaaa_0000);
    check("c_rdy1_a", bus.req1_msg_rdy, 0);
    tick();
    bus.core_res = Dig1; bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    check("c_res_id_a", bus.res_id, 0);
    tick();
    check("c_gnt_b", bus.gnt_id, 1);
    check("c_core_d_b", bus.core_msg_d, 32'hbbbb_0000);
    check("c_vb_b", bus.core_msg_vld_byte, 4'h1);
    check("c_rdy1_b", bus.req1_msg_rdy, 1);
    check("c_rdy0_b", bus.req0_msg_rdy, 0);
    tick();
    bus.core_res = Dig2; bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    check("c_res_id_b", bus.res_id, 1);
    check("c_res_d_b", bus.res_d, Dig2);
    tick();
    check("c_gnt_c", bus.gnt_id, 0);
    tick();
    bus.req0_msg_vld = 1'b0; bus.req1_msg_vld = 1'b0;
    bus.req0_msg_lst = 1'b0; bus.req1_msg_lst = 1'b0;
    bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    check("c_done", bus.busy, 0);

    // Backpressure: transfers only when core_msg_rdy is high.
    bus.core_msg_rdy = 1'b0;
    bus.req0_msg_vld = 1'b1; bus.req0_msg_d = 32'hc0c0_c0c0; bus.req0_msg_vld_byte = 4'h3;
    tick();
    check("bp_core_d0", bus.core_msg_d, 32'hc0c0_c0c0);
    check("bp_vb0", bus.core_msg_vld_byte, 4'h3);
    check("bp_rdy0_lo", bus.req0_msg_rdy, 0);
    tick();
    bus.core_msg_rdy = 1'b1;
    #1;
    check("bp_rdy0_hi", bus.req0_msg_rdy, 1);
    tick();
    bus.req0_msg_d = 32'hc1c1_c1c1; bus.req0_msg_vld_byte = 4'hc; bus.req0_msg_lst = 1'b1;
    bus.core_msg_rdy = 1'b0;
    #1;
    check("bp_core_d1", bus.core_msg_d, 32'hc1c1_c1c1);
    check("bp_vb1", bus.core_msg_vld_byte, 4'hc);
    tick();
    bus.core_msg_rdy = 1'b1;
    #1;
    check("bp_lst_held", bus.core_msg_vld, 1);
    tick();
    bus.req0_msg_vld = 1'b0; bus.req0_msg_lst = 1'b0;
    #1;
    check("bp_wait_vld", bus.core_msg_vld, 0);
    check("bp_wait_busy", bus.busy, 1);

    // Timeout: TMO=8, no digest; tmo_err 8 cycles after WAIT_RES entry.
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("tmo_early", bus.tmo_err, 0);
    end
    tick();
    check("tmo_pulse", bus.tmo_err, 1);
    check("tmo_idle", bus.busy, 0);
    check("tmo_no_res", bus.res_vld, 0);
    tick();
    check("tmo_one_cycle", bus.tmo_err, 0);

    // Priority flipped to 1: both request, req1 wins.
    bus.req0_msg_vld = 1'b1; bus.req0_msg_lst = 1'b1;
    bus.req1_msg_vld = 1'b1; bus.req1_msg_lst = 1'b1;
    tick();
    check("tmo_prio_gnt", bus.gnt_id, 1);
    tick();
    bus.req0_msg_vld = 1'b0; bus.req1_msg_vld = 1'b0;
    bus.req0_msg_lst = 1'b0; bus.req1_msg_lst = 1'b0;

    // Digest arrives in the expiry cycle: result wins.
    for (int i = 1; i <= 7; i++) tick();
    bus.core_res = Dig3; bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    check("race_res_vld", bus.res_vld, 1);
    check("race_tmo", bus.tmo_err, 0);
    check("race_res_id", bus.res_id, 1);
    tick();
    check("race_tmo_late", bus.tmo_err, 0);

    // Stray digest in IDLE.
    bus.core_res = Dig1; bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    check("stray_res_vld", bus.res_vld, 0);
    check("stray_busy", bus.busy, 0);
    check("stray_res_d", bus.res_d, Dig3);

    // Make prio=1 via a req0 job, then reset mid-stream of a req1 message.
    bus.req0_msg_vld = 1'b1; bus.req0_msg_lst = 1'b1;
    tick(); tick();
    bus.req0_msg_vld = 1'b0; bus.req0_msg_lst = 1'b0;
    bus.core_res = Dig2; bus.core_res_vld = 1'b1;
    tick();
    bus.core_res_vld = 1'b0;
    bus.req1_msg_vld = 1'b1; bus.req1_msg_d = 32'h1;
    tick();
    check("r_gnt1", bus.gnt_id, 1);
    tick();
    bus.req1_msg_d = 32'h2;
    tick();
    bus.req1_msg_d = 32'h3;
    #2 rst = 1'b1;
    #1;
    check("r_busy", bus.busy, 0);
    check("r_gnt", bus.gnt_id, 0);
    check("r_res_d", bus.res_d, 0);
    check("r_res_id", bus.res_id, 0);
    check("r_rdy1", bus.req1_msg_rdy, 0);
    check("r_core_vld", bus.core_msg_vld, 0);
    bus.req0_msg_vld = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("r_idle_rdy0", bus.req0_msg_rdy, 0);
    tick();
    check("r_prio0_gnt", bus.gnt_id, 0);
    check("r_prio0_rdy0", bus.req0_msg_rdy, 1);
    check("r_no_tmo", bus.tmo_err, 0);
    check("r_no_res", bus.res_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sm3_arb.md
SM3_ARB -- requirements
Module: sm3_arb

Interface
REQ-001 Parameter DW, default 32, message word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter TMO, default 1024, result-wait timeout in clk cycles.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 reqN_msg_d  input  DW  message word from requester N (N = 0, 1).
REQ-006 reqN_msg_vld_byte  input  DW/8  valid-byte mask of reqN_msg_d.
REQ-007 reqN_msg_vld  input  1  requester N word valid.
REQ-008 reqN_msg_lst  input  1  last word of requester N message.
REQ-009 reqN_msg_rdy  output  1  arbiter accepts requester N word.
REQ-010 core_msg_d / core_msg_vld_byte / core_msg_vld / core_msg_lst  output  DW / DW/8 / 1 / 1  message stream to the shared SM3 core.
REQ-011 core_msg_rdy  input  1  core accepts word.
REQ-012 core_res  input  256  core digest; core_res_vld  input  1  digest valid, single-cycle pulse.
REQ-013 res_d  output  256  registered digest; res_id  output  1  owning requester; res_vld  output  1  one-cycle pulse.
REQ-014 tmo_err  output  1  one-cycle pulse on result timeout; busy  output  1  high whenever state is not IDLE; gnt_id  output  1  current grant owner.

Function
REQ-015 Transfer occurs on a port only when vld and rdy are both high in the same cycle.
REQ-016 FSM states: IDLE, STREAM, WAIT_RES; encoding free, no other reachable states.
REQ-017 IDLE: if exactly one reqN_msg_vld is high, register gnt_id = N and go to STREAM next cycle.
REQ-018 IDLE with both requests high: grant the requester named by the 1-bit priority pointer prio.
REQ-019 IDLE: all reqN_msg_rdy and core_msg_vld SHALL be 0; no word is consumed in IDLE.
REQ-020 STREAM: core_msg_d/vld_byte/vld/lst combinationally equal the granted requester's inputs; granted reqN_msg_rdy = core_msg_rdy; non-granted rdy = 0.
REQ-021 STREAM: the cycle a word with lst = 1 transfers, go to WAIT_RES; otherwise remain, including while the granted requester deasserts vld mid-message.
REQ-022 STREAM has no timeout; a stalled message holds the grant indefinitely.
REQ-023 WAIT_RES and IDLE: core_msg_vld = 0, core_msg_d/vld_byte/lst = 0, all reqN_msg_rdy = 0.
REQ-024 WAIT_RES: 16-bit counter tcnt cleared on entry, increments each cycle without core_res_vld.
REQ-025 WAIT_RES with core_res_vld: next cycle res_d = core_res, res_id = gnt_id, res_vld = 1 for one cycle; prio = ~gnt_id; state to IDLE.
REQ-026 WAIT_RES with tcnt reaching TMO-1 and no core_res_vld: tmo_err pulses next cycle, prio = ~gnt_id, state to IDLE, res_vld stays 0.
REQ-027 core_res_vld in the same cycle as timeout expiry: the result wins; no tmo_err.
REQ-028 core_res_vld outside WAIT_RES is ignored: no res_vld, no state change.
REQ-029 res_d and res_id hold their value until the next res_vld; gnt_id holds until the next grant.
REQ-030 Latency: request sampled in IDLE at cycle n; first word can transfer at n+1; res_vld asserts one cycle after core_res_vld.

Reset
REQ-031 While rst is high, state = IDLE, prio = 0, gnt_id = 0, tcnt = 0, res_d = 0, res_id = 0, res_vld = 0, tmo_err = 0, busy = 0; all rdy and core_msg_vld = 0.
REQ-032 rst asserted mid-STREAM or mid-WAIT_RES aborts immediately and asynchronously; the partial message is dropped; no res_vld or tmo_err is generated for it.

Verification
REQ-033 Single requester: req0 sends 3 words, last with lst = 1; core returns digest 0x66c7f0f4...8f4ba8e0 -> res_vld one cycle later, res_id = 0, res_d equals the digest.
REQ-034 Contention: req0 and req1 both vld in IDLE after reset -> req0 granted first; req1 granted after req0 result; with both still requesting, req0 granted next (alternation).
REQ-035 Backpressure: core_msg_rdy toggled 1010 during STREAM -> transfers only on rdy = 1 cycles; word order and vld_byte preserved.
REQ-036 Timeout: TMO = 8, no core_res_vld -> tmo_err pulses 8 cycles after WAIT_RES entry; state IDLE; res_vld never asserted; prio flipped.
REQ-037 Boundary: core_res_vld in the expiry cycle -> res_vld = 1, tmo_err = 0; stray core_res_vld in IDLE -> no output.
REQ-038 Reset mid-STREAM after 2 words -> all outputs at reset values; req1 request after release is granted per prio = 0 rules.
